// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBP/TLBR/TLBWI retiring in write-back: drives TLB search/read/write ports and CP0 commits.
// Define TLB_REFETCH_EN to add the post-op refetch request after TLBR/TLBWI.
module tlb_op_ctrl #(
    parameter  int TLBNUM = 16,
    localparam int IDX_W  = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_pc,
    output logic             req_ready,
    output logic             busy,
    input  logic [31:0]      cp0_entryhi,
    input  logic [31:0]      cp0_index,
    output logic [18:0]      s_vpn2,
    output logic [7:0]       s_asid,
    input  logic             s_found,
    input  logic [IDX_W-1:0] s_index,
    output logic [IDX_W-1:0] r_index,
    output logic             tlb_we,
    output logic [IDX_W-1:0] w_index,
    output logic             index_wen,
    output logic [31:0]      index_wdata,
    output logic             tlbr_wen,
    output logic             refetch_valid,
    output logic [31:0]      refetch_pc
);

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_TLBP  = 2'b01;
    localparam logic [1:0] OP_TLBR  = 2'b10;
    localparam logic [1:0] OP_TLBWI = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        COMMIT,
        REFETCH
    } state_t;

    // Where TLBR (after COMMIT) and TLBWI (after ISSUE) go once their strobes are done.
`ifdef TLB_REFETCH_EN
    localparam state_t POST_OP = REFETCH;
`else
    localparam state_t POST_OP = IDLE;
`endif

    state_t           state_reg;
    logic [1:0]       op_reg;
    logic [18:0]      vpn2_reg;
    logic [7:0]       asid_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             found_reg;
    logic [IDX_W-1:0] sidx_reg;
    logic [31:0]      pc_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            op_reg    <= OP_NONE;
            vpn2_reg  <= '0;
            asid_reg  <= '0;
            idx_reg   <= '0;
            found_reg <= 1'b0;
            sidx_reg  <= '0;
            pc_reg    <= '0;
        end else if (flush) begin
            // Aborts an op in flight and blocks acceptance while idle.
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid && req_op != OP_NONE) begin
                        op_reg    <= req_op;
                        pc_reg    <= req_pc;
                        vpn2_reg  <= cp0_entryhi[31:13];
                        asid_reg  <= cp0_entryhi[7:0];
                        idx_reg   <= cp0_index[IDX_W-1:0];
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    found_reg <= s_found;
                    sidx_reg  <= s_index;
                    state_reg <= (op_reg == OP_TLBWI) ? POST_OP : CAPTURE;
                end
                CAPTURE: state_reg <= COMMIT;
                COMMIT:  state_reg <= (op_reg == OP_TLBR) ? POST_OP : IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign s_vpn2    = vpn2_reg;
    assign s_asid    = asid_reg;
    assign r_index   = idx_reg;
    assign w_index   = idx_reg;

    assign tlb_we      = !flush && state_reg == ISSUE  && op_reg == OP_TLBWI;
    assign index_wen   = !flush && state_reg == COMMIT && op_reg == OP_TLBP;
    assign tlbr_wen    = !flush && state_reg == COMMIT && op_reg == OP_TLBR;
    assign index_wdata = (state_reg == COMMIT && op_reg == OP_TLBP)
                       ? {~found_reg, {(31-IDX_W){1'b0}}, sidx_reg} : '0;

    logic unused_bits;
`ifdef TLB_REFETCH_EN
    assign refetch_valid = !flush && state_reg == REFETCH;
    assign refetch_pc    = pc_reg + 32'd4;
    assign unused_bits   = ^{cp0_index[31:IDX_W], cp0_entryhi[12:8]};
`else
    assign refetch_valid = 1'b0;
    assign refetch_pc    = '0;
    assign unused_bits   = ^{cp0_index[31:IDX_W], cp0_entryhi[12:8], pc_reg};
`endif

endmodule
